// File: rtl/dnn_image_loader_fix9_if.sv
// Signal bundle between the image loader and its environment: pixel stream,
// activation-memory write port, engine control/status and result handshake.
interface dnn_image_loader_fix9_if #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 16,
    parameter int N_CLASSES  = 10
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [DATA_WIDTH-1:0]                in_data;
    logic                                 in_last;
    logic                                 wr_en;
    logic [ADDR_WIDTH-1:0]                wr_addr;
    logic [DATA_WIDTH-1:0]                wr_data;
    logic                                 mem_owner;
    logic                                 dnn_reset;
    logic                                 dnn_start;
    logic                                 dnn_done;
    logic [N_CLASSES-1:0][DATA_WIDTH-1:0] dnn_out;
    logic                                 res_valid;
    logic                                 res_ready;
    logic [3:0]                           res_class;
    logic                                 err;

    // Loader side: consumes pixels and engine status, drives memory and control.
    modport slave (
        input  in_valid, in_data, in_last, dnn_done, dnn_out, res_ready,
        output in_ready, wr_en, wr_addr, wr_data, mem_owner, dnn_reset,
               dnn_start, res_valid, res_class, err
    );

    // Environment side: pixel source, memory, engine and result consumer.
    modport master (
        output in_valid, in_data, in_last, dnn_done, dnn_out, res_ready,
        input  in_ready, wr_en, wr_addr, wr_data, mem_owner, dnn_reset,
               dnn_start, res_valid, res_class, err
    );
endinterface

// File: rtl/dnn_image_loader_fix9.sv
// Frame loader and result reader for the 9-bit fixed-point sigmoid DNN engine.
// Streams one 20x20 Q1.7 image into the activation region, appends the bias
// word, kicks the engine, then reduces its outputs to an argmax class.
// All outputs are registered; the engine start pulse lands three cycles after
// the last pixel is accepted (pixel write, bias write, start).
module dnn_image_loader_fix9 #(
    parameter int                    DATA_WIDTH  = 9,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
    parameter int                    N_PIXELS    = 400,
    parameter logic [DATA_WIDTH-1:0] BIAS_VAL    = 9'h080,
    parameter int                    N_CLASSES   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    dnn_image_loader_fix9_if.slave  bus
);
    localparam int CNT_W = $clog2(N_PIXELS + 1);
    localparam int IDX_W = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_BIAS   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ARGMAX = 3'd5;
    localparam logic [2:0] ST_RESULT = 3'd6;

    logic [2:0]                   state_r;
    logic [2:0]                   state_nxt_s;
    logic [CNT_W-1:0]             cnt_r;
    logic [IDX_W-1:0]             idx_r;
    logic signed [DATA_WIDTH-1:0] cap_r [N_CLASSES];
    logic signed [DATA_WIDTH-1:0] max_r;
    logic [IDX_W-1:0]             max_idx_r;

    logic                         in_ready_r;
    logic                         wr_en_r;
    logic [ADDR_WIDTH-1:0]        wr_addr_r;
    logic [DATA_WIDTH-1:0]        wr_data_r;
    logic                         mem_owner_r;
    logic                         dnn_reset_r;
    logic                         dnn_start_r;
    logic                         res_valid_r;
    logic [3:0]                   res_class_r;
    logic                         err_r;

    logic                         accept_s;
    logic                         final_pix_s;
    logic                         len_err_s;
    logic                         capture_s;
    logic                         handshake_s;
    logic                         arg_done_s;
    logic signed [DATA_WIDTH-1:0] cur_s;
    logic                         take_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.mem_owner = mem_owner_r;
    assign bus.dnn_reset = dnn_reset_r;
    assign bus.dnn_start = dnn_start_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_class = res_class_r;
    assign bus.err       = err_r;

    // Handshake qualifiers; engine done is ignored while the start pulse is out.
    always_comb begin
        accept_s    = (state_r == ST_LOAD) && bus.in_valid && in_ready_r;
        final_pix_s = (cnt_r == CNT_W'(N_PIXELS - 1));
        len_err_s   = accept_s && (bus.in_last != final_pix_s);
        capture_s   = (state_r == ST_RUN) && bus.dnn_done && !dnn_start_r;
        handshake_s = (state_r == ST_RESULT) && res_valid_r && bus.res_ready;
        arg_done_s  = (idx_r == IDX_W'(N_CLASSES - 1));
    end

    // Argmax candidate: first element always seeds, later ones must be strictly greater.
    always_comb begin
        cur_s = '0;
        if (idx_r < IDX_W'(N_CLASSES)) begin
            cur_s = cap_r[idx_r];
        end else begin
            cur_s = '0;
        end
        take_s = (idx_r == IDX_W'(0)) || (cur_s > max_r);
    end

    // Next-state logic for the frame sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = ST_LOAD;
            ST_LOAD: begin
                if (accept_s && bus.in_last && final_pix_s) begin
                    state_nxt_s = ST_BIAS;
                end else if (len_err_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_BIAS:   state_nxt_s = ST_START;
            ST_START:  state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (capture_s) begin
                    state_nxt_s = ST_ARGMAX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ARGMAX: begin
                if (arg_done_s) begin
                    state_nxt_s = ST_RESULT;
                end else begin
                    state_nxt_s = ST_ARGMAX;
                end
            end
            ST_RESULT: begin
                if (handshake_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESULT;
                end
            end
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and control pulses derived from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            dnn_reset_r <= 1'b0;
            dnn_start_r <= 1'b0;
            mem_owner_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_LOAD);
            dnn_reset_r <= (state_r == ST_IDLE);
            dnn_start_r <= (state_r == ST_START);
            mem_owner_r <= (state_r == ST_START) || (state_r == ST_RUN);
            err_r       <= len_err_s;
        end
    end

    // Pixel counter and activation-memory write port (pixels, then bias).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            if (state_r == ST_IDLE) begin
                cnt_r <= '0;
            end else if (accept_s) begin
                cnt_r <= (bus.in_last || final_pix_s) ? CNT_W'(0) : cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (accept_s) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= ADDR_BASE_A + ADDR_WIDTH'(cnt_r);
                wr_data_r <= bus.in_data;
            end else if (state_r == ST_BIAS) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= ADDR_BASE_A + ADDR_WIDTH'(N_PIXELS);
                wr_data_r <= BIAS_VAL;
            end else begin
                wr_en_r   <= 1'b0;
            end
        end
    end

    // Engine output capture, sequential argmax scan and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                cap_r[i] <= '0;
            end
            idx_r       <= '0;
            max_r       <= '0;
            max_idx_r   <= '0;
            res_valid_r <= 1'b0;
            res_class_r <= 4'd0;
        end else begin
            if (capture_s) begin
                for (int i = 0; i < N_CLASSES; i++) begin
                    cap_r[i] <= bus.dnn_out[i];
                end
                idx_r <= '0;
            end else if (state_r == ST_ARGMAX) begin
                if (take_s) begin
                    max_r     <= cur_s;
                    max_idx_r <= idx_r;
                end
                idx_r <= idx_r + IDX_W'(1);
                if (arg_done_s) begin
                    res_class_r <= take_s ? 4'(idx_r) : 4'(max_idx_r);
                    res_valid_r <= 1'b1;
                end
            end else if (handshake_s) begin
                res_valid_r <= 1'b0;
            end else begin
                res_valid_r <= res_valid_r;
            end
        end
    end
endmodule

// File: tb/tb_dnn_image_loader_fix9.sv
// Directed bench for the DNN image loader: ramp frames, source backpressure,
// argmax ties, frame-length error, result backpressure and reset during RUN.
module tb_dnn_image_loader_fix9;
    localparam int N_PIX = 400;
    localparam int N_CLS = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dnn_image_loader_fix9_if bus ();

    dnn_image_loader_fix9 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] wa_q [$];
    logic [8:0]  wd_q [$];
    int n_start   = 0;
    int n_errp    = 0;
    int n_overlap = 0;

    // Write/pulse monitor sampling the registered outputs at each rising edge.
    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wa_q.push_back(bus.wr_addr);
            wd_q.push_back(bus.wr_data);
        end
        if (bus.dnn_start === 1'b1) n_start <= n_start + 1;
        if (bus.err === 1'b1) n_errp <= n_errp + 1;
        if (bus.wr_en === 1'b1 && bus.mem_owner === 1'b1) n_overlap <= n_overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CLS-1:0][8:0] pack(input int v [N_CLS]);
        logic [N_CLS-1:0][8:0] r;
        for (int i = 0; i < N_CLS; i++) r[i] = 9'(v[i]);
        return r;
    endfunction

    // Offer one pixel after 'gap' idle cycles; returns on the negedge after acceptance.
    task automatic send_pixel(input logic [8:0] d, input logic last, input int gap);
        int guard;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 32'(guard), 32'd0);
        @(negedge clk);
    endtask

    // Ramp frame of pixels 0..last_idx, in_last on last_idx, optional source gaps.
    task automatic send_frame(input int last_idx, input bit gaps);
        int gap;
        for (int i = 0; i <= last_idx; i++) begin
            gap = 0;
            if (gaps) gap = (i % 4 == 1) ? 1 : ((i % 9 == 5) ? 3 : 0);
            send_pixel(9'(i & 255), (i == last_idx), gap);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Last pixel write, bias write, then start pulse with memory handed over.
    task automatic post_frame_checks(input string tag);
        chk({tag, "_pix_wr_en"}, 32'(bus.wr_en), 32'd1);
        chk({tag, "_pix_addr"}, 32'(bus.wr_addr), 32'h18F);
        chk({tag, "_pix_data"}, 32'(bus.wr_data), 32'h08F);
        @(negedge clk);
        chk({tag, "_bias_wr"}, 32'({bus.wr_en, bus.mem_owner, bus.dnn_start}), 32'b100);
        chk({tag, "_bias_addr"}, 32'(bus.wr_addr), 32'h190);
        chk({tag, "_bias_data"}, 32'(bus.wr_data), 32'h080);
        @(negedge clk);
        chk({tag, "_start"}, 32'({bus.wr_en, bus.mem_owner, bus.dnn_start}), 32'b011);
    endtask

    // Writes since 'base' must be addresses 0..n-1 with ramp data, plus bias if asked.
    task automatic check_writes(input string tag, input int base, input int n, input bit bias);
        int bad;
        int got;
        bad = 0;
        got = wa_q.size() - base;
        chk({tag, "_wr_count"}, 32'(got), 32'(n + (bias ? 1 : 0)));
        for (int i = 0; i < n && i < got; i++) begin
            if (wa_q[base + i] !== 16'(i) || wd_q[base + i] !== 9'(i & 255)) bad++;
        end
        if (bias && got > n) begin
            if (wa_q[base + n] !== 16'h0190 || wd_q[base + n] !== 9'h080) bad++;
        end
        chk({tag, "_wr_order"}, 32'(bad), 32'd0);
    endtask

    // Engine model: done 3 cycles after start; checks result timing and class.
    task automatic engine(input string tag, input int v [N_CLS], input int exp_class);
        int early;
        repeat (3) @(negedge clk);
        bus.dnn_out  = pack(v);
        bus.dnn_done = 1'b1;
        early = 0;
        for (int k = 1; k <= N_CLS; k++) begin
            @(negedge clk);
            bus.dnn_done = 1'b0;
            if (bus.res_valid !== 1'b0) early++;
        end
        chk({tag, "_res_early"}, 32'(early), 32'd0);
        @(negedge clk);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        chk({tag, "_res_class"}, 32'(bus.res_class), 32'(exp_class));
    endtask

    int p1 [N_CLS] = '{0, -1, 5, -128, 20, 19, -3, 100, 99, -100};
    int p3 [N_CLS] = '{-5, 3, 7, 7, -128, 0, 1, 2, 6, -1};
    int p9 [N_CLS] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        int base;
        int snap_start;
        int snap_err;
        int unstable;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.dnn_done = 1'b0;
        bus.dnn_out = '0;
        bus.res_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({bus.in_ready, bus.wr_en, bus.mem_owner, bus.dnn_reset,
                                  bus.dnn_start, bus.res_valid, bus.res_class, bus.err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("boot_reset_ready", 32'({bus.dnn_reset, bus.in_ready}), 32'b11);
        @(negedge clk);
        chk("boot_reset_pulse", 32'({bus.dnn_reset, bus.in_ready}), 32'b01);

        // Test 1: ramp frame, no gaps; result consumed immediately
        base = wa_q.size();
        send_frame(N_PIX - 1, 1'b0);
        post_frame_checks("t1");
        check_writes("t1", base, N_PIX, 1'b1);
        engine("t1", p1, 7);
        @(negedge clk);
        chk("t1_res_taken", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("t1_rearm", 32'({bus.dnn_reset, bus.in_ready}), 32'b11);

        // Tests 2, 3, 5: gappy frame, tie argmax, held result
        bus.res_ready = 1'b0;
        base = wa_q.size();
        send_frame(N_PIX - 1, 1'b1);
        post_frame_checks("t2");
        check_writes("t2", base, N_PIX, 1'b1);
        engine("t3", p3, 2);
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_class !== 4'd2) unstable++;
        end
        chk("t5_hold_stable", 32'(unstable), 32'd0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("t5_res_taken", 32'({bus.res_valid, bus.in_ready}), 32'b00);
        @(negedge clk);
        chk("t5_rearm", 32'({bus.dnn_reset, bus.in_ready}), 32'b11);

        // Test 4: in_last on pixel 10
        base = wa_q.size();
        snap_start = n_start;
        snap_err = n_errp;
        send_frame(10, 1'b0);
        chk("t4_err_pulse", 32'({bus.err, bus.wr_en, bus.in_ready}), 32'b110);
        chk("t4_last_addr", 32'(bus.wr_addr), 32'h00A);
        @(negedge clk);
        chk("t4_after", 32'({bus.err, bus.wr_en, bus.dnn_reset, bus.in_ready}), 32'b0011);
        repeat (5) @(negedge clk);
        check_writes("t4", base, 11, 1'b0);
        chk("t4_no_start", 32'(n_start - snap_start), 32'd0);
        chk("t4_err_count", 32'(n_errp - snap_err), 32'd1);

        // Next frame reloads from 0x0000; reset while engine runs
        base = wa_q.size();
        send_frame(N_PIX - 1, 1'b0);
        post_frame_checks("t4b");
        check_writes("t4b", base, N_PIX, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_reset_outputs", 32'({bus.in_ready, bus.wr_en, bus.mem_owner, bus.dnn_reset,
                                     bus.dnn_start, bus.res_valid, bus.res_class, bus.err}), 32'd0);
        chk("t6_reset_bus", 32'({bus.wr_addr, bus.wr_data}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rearm", 32'({bus.dnn_reset, bus.in_ready}), 32'b11);

        // Test 6 follow-up: full frame behaves as test 1
        bus.res_ready = 1'b1;
        base = wa_q.size();
        send_frame(N_PIX - 1, 1'b0);
        post_frame_checks("t6");
        check_writes("t6", base, N_PIX, 1'b1);
        engine("t6", p9, 9);
        @(negedge clk);
        chk("t6_res_taken", 32'(bus.res_valid), 32'd0);

        chk("start_total", 32'(n_start), 32'd4);
        chk("err_total", 32'(n_errp), 32'd1);
        chk("wr_owner_overlap", 32'(n_overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
